// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC requantiser.
//   state_e         - window FSM encoding (accumulate / one-cycle drain)
//   DEF_LEN_ACC     - default accumulator width
//   DEF_LEN_OUT     - default output width
//   DEF_SHIFT_W     - default shift-control width
package mac_pkg;

    typedef enum logic {
        StAccum = 1'b0,
        StDrain = 1'b1
    } state_e;

    localparam int unsigned DEF_LEN_ACC = 18;
    localparam int unsigned DEF_LEN_OUT = 8;
    localparam int unsigned DEF_SHIFT_W = 5;

endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational round-half-up, arithmetic right shift, optional ReLU and
// saturation of a signed accumulator value to a narrower signed result.
//   acc     in  LEN_ACC signed  value to requantise
//   shift   in  SHIFT_W         right-shift amount, 0..LEN_ACC-1
//   relu_en in  1               clamp negative results to zero
//   data    out LEN_OUT signed  requantised result
//   sat     out 1               result was clamped to the output range
module requant_sat
    import mac_pkg::*;
#(
    parameter int unsigned LEN_ACC = DEF_LEN_ACC,
    parameter int unsigned LEN_OUT = DEF_LEN_OUT,
    parameter int unsigned SHIFT_W = DEF_SHIFT_W
) (
    input  logic signed [LEN_ACC-1:0] acc,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      relu_en,
    output logic signed [LEN_OUT-1:0] data,
    output logic                      sat
);

    // One guard bit so acc + 2^(shift-1) can never wrap.
    localparam int unsigned W = LEN_ACC + 1;

    localparam logic signed [W-1:0] MAX_V = {{(W - LEN_OUT + 1){1'b0}}, {(LEN_OUT - 1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {{(W - LEN_OUT + 1){1'b1}}, {(LEN_OUT - 1){1'b0}}};

    logic signed [W-1:0] ext;
    logic signed [W-1:0] bias;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] rnd;

    always_comb begin
        ext  = {acc[LEN_ACC-1], acc};
        bias = '0;
        if (shift != '0) begin
            bias = {{(W - 1){1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
        end
        sum = ext + bias;
        rnd = sum >>> shift;

        data = rnd[LEN_OUT-1:0];
        sat  = 1'b0;
        if (relu_en && rnd[W-1]) begin
            // ReLU clamp is not a saturation event.
            data = '0;
        end else if (rnd > MAX_V) begin
            data = MAX_V[LEN_OUT-1:0];
            sat  = 1'b1;
        end else if (rnd < MIN_V) begin
            data = MIN_V[LEN_OUT-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/mac_requant.sv
// mac_requant: counts N_TAPS MAC steps per window, then spends one drain cycle pulsing
// MAC_CLR while capturing the finished sum, requantises it and presents it on a
// valid/ready output register. A result that cannot be accepted is dropped and OVERRUN
// sticks until reset.
//   CLK        in  1               rising-edge clock
//   SYNC_RST   in  1               synchronous active-high reset
//   ACC_IN     in  LEN_ACC signed  running sum from the upstream MAC
//   ACC_VALID  in  1               a MAC step was applied at this edge
//   SHIFT      in  SHIFT_W         right-shift amount
//   RELU_EN    in  1               clamp negative results to zero
//   OUT_READY  in  1               downstream accepts DATA_OUT
//   MAC_CLR    out 1               restarts the upstream accumulator
//   DATA_OUT   out LEN_OUT signed  requantised result
//   OUT_VALID  out 1               DATA_OUT holds an unaccepted result
//   SAT_FLAG   out 1               current DATA_OUT was saturated
//   OVERRUN    out 1               sticky: a result was dropped
module mac_requant
    import mac_pkg::*;
#(
    parameter int unsigned LEN_ACC = DEF_LEN_ACC,
    parameter int unsigned LEN_OUT = DEF_LEN_OUT,
    parameter int unsigned N_TAPS  = 16,
    parameter int unsigned SHIFT_W = DEF_SHIFT_W
) (
    input  logic                      CLK,
    input  logic                      SYNC_RST,
    input  logic signed [LEN_ACC-1:0] ACC_IN,
    input  logic                      ACC_VALID,
    input  logic        [SHIFT_W-1:0] SHIFT,
    input  logic                      RELU_EN,
    input  logic                      OUT_READY,
    output logic                      MAC_CLR,
    output logic signed [LEN_OUT-1:0] DATA_OUT,
    output logic                      OUT_VALID,
    output logic                      SAT_FLAG,
    output logic                      OVERRUN
);

    localparam int unsigned CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TAPS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic signed [LEN_ACC-1:0] cap_acc_q;
    logic [SHIFT_W-1:0]        cap_shift_q;
    logic                      cap_valid_q;

    logic signed [LEN_OUT-1:0] rq_data;
    logic                      rq_sat;

    logic signed [LEN_OUT-1:0] data_q;
    logic                      out_valid_q;
    logic                      sat_q;
    logic                      overrun_q;
    logic                      load;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StAccum: begin
                if (ACC_VALID) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            // ACC_VALID is deliberately ignored here.
            StDrain: state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    requant_sat #(
        .LEN_ACC (LEN_ACC),
        .LEN_OUT (LEN_OUT),
        .SHIFT_W (SHIFT_W)
    ) u_requant_sat (
        .acc     (cap_acc_q),
        .shift   (cap_shift_q),
        .relu_en (RELU_EN),
        .data    (rq_data),
        .sat     (rq_sat)
    );

    // Load when the output slot is empty or is being emptied this very cycle.
    assign load = cap_valid_q && (!out_valid_q || OUT_READY);

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state_q     <= StAccum;
            cnt_q       <= '0;
            cap_acc_q   <= '0;
            cap_shift_q <= '0;
            cap_valid_q <= 1'b0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_valid_q <= (state_q == StDrain);
            if (state_q == StDrain) begin
                cap_acc_q   <= ACC_IN;
                cap_shift_q <= SHIFT;
            end
            if (load) begin
                data_q      <= rq_data;
                sat_q       <= rq_sat;
                out_valid_q <= 1'b1;
            end else if (OUT_READY) begin
                out_valid_q <= 1'b0;
            end
            if (cap_valid_q && !load) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign MAC_CLR   = (state_q == StDrain);
    assign DATA_OUT  = data_q;
    assign OUT_VALID = out_valid_q;
    assign SAT_FLAG  = sat_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_mac_requant.sv
// tb_mac_requant: directed, table-driven bench for mac_requant with N_TAPS=4.
module tb_mac_requant;

    localparam int N_TAPS = 4;

    logic               CLK = 1'b0;
    logic               SYNC_RST;
    logic signed [17:0] ACC_IN;
    logic               ACC_VALID;
    logic [4:0]         SHIFT;
    logic               RELU_EN;
    logic               OUT_READY;
    logic               MAC_CLR;
    logic signed [7:0]  DATA_OUT;
    logic               OUT_VALID;
    logic               SAT_FLAG;
    logic               OVERRUN;

    mac_requant #(
        .LEN_ACC (18),
        .LEN_OUT (8),
        .N_TAPS  (N_TAPS),
        .SHIFT_W (5)
    ) dut (
        .CLK       (CLK),
        .SYNC_RST  (SYNC_RST),
        .ACC_IN    (ACC_IN),
        .ACC_VALID (ACC_VALID),
        .SHIFT     (SHIFT),
        .RELU_EN   (RELU_EN),
        .OUT_READY (OUT_READY),
        .MAC_CLR   (MAC_CLR),
        .DATA_OUT  (DATA_OUT),
        .OUT_VALID (OUT_VALID),
        .SAT_FLAG  (SAT_FLAG),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    // Transfer / MAC_CLR monitor.
    int cyc = 0;
    int xfer_cnt = 0;
    int last_xfer = 0;
    int clr_cnt = 0;
    int xfer_cyc[$];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (OUT_VALID && OUT_READY) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_xfer <= int'(DATA_OUT);
            xfer_cyc.push_back(cyc);
        end
        if (MAC_CLR) clr_cnt <= clr_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one window; ACC_IN carries a junk value except in the drain cycle so a
    // mistimed capture shows up as a wrong result.
    task automatic run_window(input logic signed [17:0] fin, input int sh, input bit relu,
                              input bit fresh, input bit rdy_at_load);
        SHIFT     = 5'(sh);
        RELU_EN   = relu;
        ACC_IN    = 18'sd77;
        ACC_VALID = 1'b1;
        repeat (N_TAPS) tick();
        ACC_VALID = 1'b0;
        ACC_IN    = fin;
        check("mac_clr_in_drain", int'(MAC_CLR), 1);
        tick();
        ACC_IN = 18'sd77;
        if (rdy_at_load) OUT_READY = 1'b1;
        check("mac_clr_after_drain", int'(MAC_CLR), 0);
        if (fresh) check("out_valid_at_k1", int'(OUT_VALID), 0);
        tick();
        check("out_valid_at_k2", int'(OUT_VALID), 1);
    endtask

    task automatic do_reset();
        SYNC_RST = 1'b1;
        tick();
        tick();
        SYNC_RST = 1'b0;
    endtask

    typedef struct {
        logic signed [17:0] acc;
        int                 shift;
        bit                 relu;
        int                 exp_data;
        int                 exp_sat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int x0, c0, gap_bad;

        vecs[0]  = '{18'sd1000,    3,  1'b0, 125,  0};
        vecs[1]  = '{18'sd1004,    3,  1'b0, 126,  0};
        vecs[2]  = '{-18'sd1004,   3,  1'b0, -125, 0};
        vecs[3]  = '{-18'sd375,    0,  1'b0, -128, 1};
        vecs[4]  = '{-18'sd375,    0,  1'b1, 0,    0};
        vecs[5]  = '{18'sd127,     0,  1'b0, 127,  0};
        vecs[6]  = '{18'sd128,     0,  1'b0, 127,  1};
        vecs[7]  = '{-18'sd128,    0,  1'b0, -128, 0};
        vecs[8]  = '{-18'sd129,    0,  1'b0, -128, 1};
        vecs[9]  = '{-18'sd20,     2,  1'b1, 0,    0};
        vecs[10] = '{18'sd131071,  17, 1'b0, 1,    0};
        vecs[11] = '{-18'sd131072, 17, 1'b0, -1,   0};
        vecs[12] = '{18'sd1023,    2,  1'b0, 127,  1};
        vecs[13] = '{-18'sd6,      2,  1'b0, -1,   0};
        vecs[14] = '{18'sd5,       1,  1'b1, 3,    0};

        ACC_IN = '0; ACC_VALID = 1'b0; SHIFT = '0; RELU_EN = 1'b0; OUT_READY = 1'b0;
        SYNC_RST = 1'b0;
        tick();
        do_reset();

        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_data_out", int'(DATA_OUT), 0);
        check("rst_sat_flag", int'(SAT_FLAG), 0);
        check("rst_overrun", int'(OVERRUN), 0);
        check("rst_mac_clr", int'(MAC_CLR), 0);

        // Table: one window per vector, then drain it.
        foreach (vecs[i]) begin
            c0 = clr_cnt;
            OUT_READY = 1'b0;
            run_window(vecs[i].acc, vecs[i].shift, vecs[i].relu, 1'b1, 1'b0);
            check($sformatf("data_v%0d", i), int'(DATA_OUT), vecs[i].exp_data);
            check($sformatf("sat_v%0d", i), int'(SAT_FLAG), vecs[i].exp_sat);
            check($sformatf("clr_once_v%0d", i), clr_cnt - c0, 1);
            OUT_READY = 1'b1;
            tick();
            OUT_READY = 1'b0;
            check($sformatf("drained_v%0d", i), int'(OUT_VALID), 0);
        end
        check("table_overrun", int'(OVERRUN), 0);

        // Two windows with the output stalled: second result dropped.
        x0 = xfer_cnt;
        run_window(18'sd100, 0, 1'b0, 1'b1, 1'b0);
        run_window(18'sd200, 0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stall_data_held", int'(DATA_OUT), 100);
        check("stall_overrun", int'(OVERRUN), 1);
        OUT_READY = 1'b1;
        tick();
        tick();
        tick();
        check("stall_one_xfer", xfer_cnt - x0, 1);
        check("stall_xfer_val", last_xfer, 100);
        check("overrun_sticky", int'(OVERRUN), 1);
        do_reset();
        check("overrun_cleared", int'(OVERRUN), 0);

        // Back-to-back: held result transfers on the same edge the next one loads.
        OUT_READY = 1'b0;
        x0 = xfer_cnt;
        run_window(18'sd50, 0, 1'b0, 1'b1, 1'b0);
        run_window(18'sd60, 0, 1'b0, 1'b0, 1'b1);
        check("b2b_new_data", int'(DATA_OUT), 60);
        check("b2b_first_xfer", last_xfer, 50);
        check("b2b_no_overrun", int'(OVERRUN), 0);
        tick();
        OUT_READY = 1'b0;
        check("b2b_two_xfers", xfer_cnt - x0, 2);
        check("b2b_second_val", last_xfer, 60);

        // Reset mid-window: only the post-reset window produces a result.
        x0 = xfer_cnt;
        ACC_IN = 18'sd77;
        ACC_VALID = 1'b1;
        tick();
        tick();
        ACC_VALID = 1'b0;
        SYNC_RST = 1'b1;
        tick();
        SYNC_RST = 1'b0;
        run_window(18'sd33, 0, 1'b0, 1'b1, 1'b0);
        check("midrst_data", int'(DATA_OUT), 33);
        OUT_READY = 1'b1;
        repeat (6) tick();
        check("midrst_one_xfer", xfer_cnt - x0, 1);
        check("midrst_val", last_xfer, 33);

        // Reset during drain (r=0) and with the captured result in flight (r=1).
        for (int r = 0; r < 2; r++) begin
            x0 = xfer_cnt;
            ACC_IN = 18'sd9;
            ACC_VALID = 1'b1;
            repeat (N_TAPS) tick();
            ACC_VALID = 1'b0;
            if (r == 1) tick();
            SYNC_RST = 1'b1;
            tick();
            SYNC_RST = 1'b0;
            check($sformatf("rst_flight%0d_clr", r), int'(MAC_CLR), 0);
            repeat (5) tick();
            check($sformatf("rst_flight%0d_valid", r), int'(OUT_VALID), 0);
            check($sformatf("rst_flight%0d_noxfer", r), xfer_cnt - x0, 0);
        end

        // Continuous ACC_VALID: 25 edges give 5 windows, one result every 5 cycles.
        x0 = xfer_cnt;
        xfer_cyc.delete();
        OUT_READY = 1'b1;
        SHIFT = 5'd0;
        RELU_EN = 1'b0;
        ACC_IN = 18'sd40;
        ACC_VALID = 1'b1;
        repeat (25) tick();
        ACC_VALID = 1'b0;
        repeat (6) tick();
        check("cont_count", xfer_cnt - x0, 5);
        check("cont_value", last_xfer, 40);
        check("cont_overrun", int'(OVERRUN), 0);
        gap_bad = 0;
        for (int i = 1; i < xfer_cyc.size(); i++) begin
            if (xfer_cyc[i] - xfer_cyc[i-1] != N_TAPS + 1) gap_bad++;
        end
        check("cont_spacing", gap_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
